score_counter_mc: RTL and testbench
===================================

# score_counter_mc

Multi-channel scoreboard counter, successor to the single 7-bit up/down counter. Each channel holds a score in 0..MAX_VAL and steps once per rising edge of its debounced increment or decrement button. It saturates or wraps at the limits, reports limit and clip status, and optionally provides BCD digits for the 7-segment driver. It sits between the button debouncers and the display multiplexer.

## Interface
- BW, 7: counter width per channel. Elaboration error if MAX_VAL ≥ 2**BW.
- NCH, 2: number of independent channels (home/guest).
- MAX_VAL, 99: upper count limit, inclusive.
- WRAP, 0: limit behaviour. 0 = saturate at the limits; 1 = wrap MAX_VAL↔0.
- clk_i  in  1  single clock; all state updates on its rising edge.
- rst_i  in  1  reset, synchronous and active-high.
- en_i  in  1  global count enable. Edges seen while low are discarded.
- inc_i  in  NCH  level increment request per channel; acts on the rising edge only.
- dec_i  in  NCH  level decrement request per channel; acts on the rising edge only.
- clr_i  in  NCH  synchronous per-channel clear; level-sensitive.
- cnt_o  out  NCH*BW  channel values, channel k at [k*BW +: BW].
- at_max_o  out  NCH  cnt == MAX_VAL, decoded from the register.
- at_zero_o  out  NCH  cnt == 0, decoded from the register.
- sat_o  out  NCH  sticky flag: a step was clipped at a limit (WRAP=0 only).

## Operation
- Edge detect per channel:
  - inc_q and dec_q register the previous value of inc_i and dec_i every cycle, regardless of en_i.
  - inc_ev = inc_i & ~inc_q & en_i. dec_ev is formed the same way.
- Per-channel priority: rst_i > clr_i > event.
  - clr_i=1 sets cnt to 0 and sat to 0 and ignores events that cycle.
  - inc_ev and dec_ev in the same cycle cancel: no change, sat untouched.
- inc_ev alone:
  - cnt < MAX_VAL: cnt+1.
  - cnt == MAX_VAL, WRAP=0: hold and set sat.
  - cnt == MAX_VAL, WRAP=1: cnt becomes 0.
- dec_ev alone:
  - cnt > 0: cnt−1.
  - cnt == 0, WRAP=0: hold and set sat.
  - cnt == 0, WRAP=1: cnt becomes MAX_VAL.
- Arithmetic is BW bits. The compare happens before the add or subtract, so the value never leaves 0..MAX_VAL and there is no modular roll to 2**BW−1.
- Channels are fully independent. A clear or event on one channel never affects another.
- Reset values:
  - cnt_o = 0, sat_o = 0, at_zero_o = all ones, at_max_o = 0.
  - inc_q and dec_q reset to all ones, so a button held through reset must be released and pressed again before it counts.

## Timing
- Latency: inc_i first sampled high at edge n (low at edge n−1) → cnt_o updated after edge n, visible in cycle n+1.
- One step per press: holding inc_i high gives exactly one step.
- Minimum re-press spacing: one low sample between high samples.
- at_max_o, at_zero_o and the BCD outputs are combinational from the count register and add no extra latency.
- Reset asserted mid-press: count is 0 on the next cycle, and the held button gives no step until it is released.
- en_i rising while a button is held: no step, because the edge was already absorbed.

## Configuration
- SCORE_COUNTER_BCD_EN defined:
  - Adds output bcd_o, width NCH*8, channel k at [k*8 +: 8]: {tens[3:0], ones[3:0]}.
  - Combinational from cnt.
  - Elaboration error if MAX_VAL > 99.
- SCORE_COUNTER_BCD_EN undefined: the port and its logic are absent, and MAX_VAL may be up to 2**BW−1.

## Structure
- Package score_pkg holds:
  - SCORE_BW_DEF = 7 and SCORE_MAX_DEF = 99.
  - typedef score_t = logic [SCORE_BW_DEF-1:0].
  - Limit-mode constants: LIM_SAT = 0, LIM_WRAP = 1.
- Sub-module score_bin2bcd converts a binary value (0..99) to two BCD digits. It is instantiated once per channel under SCORE_COUNTER_BCD_EN.
- Per-channel logic lives in a generate loop. There is no sub-module per channel.

## Test plan
- Reset, then inc_i[0] pulsed 3× (high 2 cycles, low 2 cycles each) → cnt ch0 = 3, ch1 = 0, at_zero_o = 2'b10.
- WRAP=0, MAX_VAL=99: 101 presses on ch1 → cnt = 99, at_max_o[1] = 1, sat_o[1] = 1. Then clr_i[1] → cnt = 0, sat_o[1] = 0.
- WRAP=1: dec press at 0 → cnt = 99 and sat_o = 0. Then inc press → cnt = 0.
- inc_i[0] and dec_i[0] rise on the same cycle at cnt = 5 → cnt stays 5. An inc rise with clr_i[0] high → cnt = 0.
- inc_i[0] held high through rst_i and through an en_i low→high transition → no step until a release and re-press, then cnt = 1 exactly one cycle after the rise.
- With SCORE_COUNTER_BCD_EN: cnt = 47 → bcd_o for that channel = 8'h47. cnt = 9 → 8'h09.

Source files
------------

// File: rtl/score_pkg.sv
// Shared defaults, score type and limit-mode constants for the multi-channel score counter.
package score_pkg;

  localparam int unsigned SCORE_BW_DEF  = 7;
  localparam int unsigned SCORE_MAX_DEF = 99;

  typedef logic [SCORE_BW_DEF-1:0] score_t;

  localparam int unsigned LIM_SAT  = 0;
  localparam int unsigned LIM_WRAP = 1;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd_t;

endpackage

// File: rtl/score_bin2bcd.sv
// Binary (0..99) to two-digit BCD for the 7-segment driver; purely combinational.
module score_bin2bcd
  import score_pkg::*;
(
  input  score_t bin_i,
  output bcd_t   bcd_o
);

  always_comb begin
    bcd_o      = '0;
    bcd_o.tens = 4'(bin_i / score_t'(10));
    bcd_o.ones = 4'(bin_i % score_t'(10));
  end

endmodule

// File: rtl/score_counter_mc.sv
// Multi-channel up/down score counter with press-edge detection, saturate/wrap limits and clip flags.
// Define SCORE_COUNTER_BCD_EN to add the per-channel BCD output bcd_o.
module score_counter_mc
  import score_pkg::*;
#(
  parameter int unsigned BW      = SCORE_BW_DEF,
  parameter int unsigned NCH     = 2,
  parameter int unsigned MAX_VAL = SCORE_MAX_DEF,
  parameter int unsigned WRAP    = LIM_SAT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic [NCH-1:0]    inc_i,
  input  logic [NCH-1:0]    dec_i,
  input  logic [NCH-1:0]    clr_i,
  output logic [NCH*BW-1:0] cnt_o,
  output logic [NCH-1:0]    at_max_o,
  output logic [NCH-1:0]    at_zero_o,
  output logic [NCH-1:0]    sat_o
`ifdef SCORE_COUNTER_BCD_EN
  ,
  output logic [NCH*8-1:0]  bcd_o
`endif
);

  if (64'(MAX_VAL) >= (64'd1 << BW)) begin : g_bw_chk
    $error("score_counter_mc: MAX_VAL does not fit in BW bits");
  end
  if (WRAP > LIM_WRAP) begin : g_wrap_chk
    $error("score_counter_mc: WRAP must be LIM_SAT or LIM_WRAP");
  end
`ifdef SCORE_COUNTER_BCD_EN
  if (MAX_VAL > 99) begin : g_bcd_chk
    $error("score_counter_mc: BCD output needs MAX_VAL <= 99");
  end
`endif

  localparam logic [BW-1:0] MAX_C = BW'(MAX_VAL);

  logic [NCH-1:0] inc_q, inc_d;
  logic [NCH-1:0] dec_q, dec_d;
  logic [NCH-1:0] inc_ev, dec_ev;

  // Previous button levels; reset high so a press held through reset must be re-pressed.
  always_comb begin
    inc_d = inc_i;
    dec_d = dec_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      inc_q <= '1;
      dec_q <= '1;
    end else begin
      inc_q <= inc_d;
      dec_q <= dec_d;
    end
  end

  assign inc_ev = inc_i & ~inc_q & {NCH{en_i}};
  assign dec_ev = dec_i & ~dec_q & {NCH{en_i}};

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic [BW-1:0] cnt_q, cnt_d;
    logic          sat_q, sat_d;

    // Limit check precedes the step, so the count never leaves 0..MAX_VAL.
    always_comb begin
      cnt_d = cnt_q;
      sat_d = sat_q;
      if (clr_i[k]) begin
        cnt_d = '0;
        sat_d = 1'b0;
      end else if (inc_ev[k] && !dec_ev[k]) begin
        if (cnt_q < MAX_C) begin
          cnt_d = cnt_q + BW'(1);
        end else if (WRAP == LIM_WRAP) begin
          cnt_d = '0;
        end else begin
          sat_d = 1'b1;
        end
      end else if (dec_ev[k] && !inc_ev[k]) begin
        if (cnt_q > '0) begin
          cnt_d = cnt_q - BW'(1);
        end else if (WRAP == LIM_WRAP) begin
          cnt_d = MAX_C;
        end else begin
          sat_d = 1'b1;
        end
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        cnt_q <= '0;
        sat_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        sat_q <= sat_d;
      end
    end

    assign cnt_o[k*BW +: BW] = cnt_q;
    assign at_max_o[k]       = (cnt_q == MAX_C);
    assign at_zero_o[k]      = (cnt_q == '0);
    assign sat_o[k]          = sat_q;

`ifdef SCORE_COUNTER_BCD_EN
    bcd_t bcd_ch;

    score_bin2bcd u_bcd (
      .bin_i (score_t'(cnt_q)),
      .bcd_o (bcd_ch)
    );

    assign bcd_o[k*8 +: 8] = bcd_ch;
`endif
  end

endmodule

// File: tb/tb_score_counter_mc.sv
// Self-checking bench for score_counter_mc: a saturating and a wrapping instance share stimulus
// and are compared every cycle against an arithmetic reference model, plus vector tables and corner sequences.
`timescale 1ns/1ps
module tb_score_counter_mc;

  localparam int unsigned BW   = 7;
  localparam int unsigned NCH  = 2;
  localparam int          MAXV = 99;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst, en;
  logic [NCH-1:0] inc, dec, clr;

  logic [NCH*BW-1:0] cnt_s, cnt_w;
  logic [NCH-1:0]    max_s, max_w, zero_s, zero_w, sat_s, sat_w;
`ifdef SCORE_COUNTER_BCD_EN
  logic [NCH*8-1:0]  bcd_s, bcd_w;
`endif

  score_counter_mc #(.BW(BW), .NCH(NCH), .MAX_VAL(MAXV), .WRAP(0)) dut_s (
    .clk_i(clk), .rst_i(rst), .en_i(en), .inc_i(inc), .dec_i(dec), .clr_i(clr),
    .cnt_o(cnt_s), .at_max_o(max_s), .at_zero_o(zero_s), .sat_o(sat_s)
`ifdef SCORE_COUNTER_BCD_EN
    , .bcd_o(bcd_s)
`endif
  );

  score_counter_mc #(.BW(BW), .NCH(NCH), .MAX_VAL(MAXV), .WRAP(1)) dut_w (
    .clk_i(clk), .rst_i(rst), .en_i(en), .inc_i(inc), .dec_i(dec), .clr_i(clr),
    .cnt_o(cnt_w), .at_max_o(max_w), .at_zero_o(zero_w), .sat_o(sat_w)
`ifdef SCORE_COUNTER_BCD_EN
    , .bcd_o(bcd_w)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: index 0 = saturating instance, 1 = wrapping instance.
  int m_cnt [2][NCH];
  bit m_sat [2][NCH];
  bit m_pinc [NCH];
  bit m_pdec [NCH];

  task automatic model_step();
    for (int k = 0; k < NCH; k++) begin
      bit ei, ed;
      ei = inc[k] && !m_pinc[k] && en;
      ed = dec[k] && !m_pdec[k] && en;
      m_pinc[k] = rst ? 1'b1 : inc[k];
      m_pdec[k] = rst ? 1'b1 : dec[k];
      for (int w = 0; w < 2; w++) begin
        int nv;
        nv = m_cnt[w][k];
        if (rst || clr[k]) begin
          nv = 0;
          m_sat[w][k] = 1'b0;
        end else if (ei != ed) begin
          nv = nv + (ei ? 1 : -1);
          if (nv > MAXV) begin
            if (w == 1) nv = 0;
            else begin nv = MAXV; m_sat[w][k] = 1'b1; end
          end else if (nv < 0) begin
            if (w == 1) nv = MAXV;
            else begin nv = 0; m_sat[w][k] = 1'b1; end
          end
        end
        m_cnt[w][k] = nv;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic check_model();
    for (int k = 0; k < NCH; k++) begin
      for (int w = 0; w < 2; w++) begin
        logic [BW-1:0] c;
        logic mx, zr, st;
        c  = (w == 0) ? cnt_s[k*BW +: BW] : cnt_w[k*BW +: BW];
        mx = (w == 0) ? max_s[k] : max_w[k];
        zr = (w == 0) ? zero_s[k] : zero_w[k];
        st = (w == 0) ? sat_s[k] : sat_w[k];
        chk($sformatf("model cnt w%0d ch%0d", w, k), 32'(c), 32'(m_cnt[w][k]));
        chk($sformatf("model at_max w%0d ch%0d", w, k), 32'(mx), 32'(m_cnt[w][k] == MAXV));
        chk($sformatf("model at_zero w%0d ch%0d", w, k), 32'(zr), 32'(m_cnt[w][k] == 0));
        chk($sformatf("model sat w%0d ch%0d", w, k), 32'(st), 32'(m_sat[w][k]));
`ifdef SCORE_COUNTER_BCD_EN
        begin
          logic [7:0] b;
          b = (w == 0) ? bcd_s[k*8 +: 8] : bcd_w[k*8 +: 8];
          chk($sformatf("model bcd w%0d ch%0d", w, k), 32'(b),
              32'(((m_cnt[w][k] / 10) << 4) | (m_cnt[w][k] % 10)));
        end
`endif
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_model();
  endtask

  task automatic press(input int ch, input bit is_dec, input int n);
    for (int i = 0; i < n; i++) begin
      if (is_dec) dec[ch] = 1'b1; else inc[ch] = 1'b1;
      tick();
      if (is_dec) dec[ch] = 1'b0; else inc[ch] = 1'b0;
      tick();
    end
  endtask

  function automatic logic [BW-1:0] ch_of(input logic [NCH*BW-1:0] v, input int k);
    return v[k*BW +: BW];
  endfunction

  typedef struct {
    bit       rst;
    bit [1:0] inc;
    bit [1:0] dec;
    bit [1:0] clr;
    int       c0;
    int       c1;
    bit [1:0] z;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit r, input bit [1:0] i, input bit [1:0] d, input bit [1:0] c,
                     input int e0, input int e1, input bit [1:0] ez);
    vec_t v;
    v.rst = r; v.inc = i; v.dec = d; v.clr = c; v.c0 = e0; v.c1 = e1; v.z = ez;
    tbl.push_back(v);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b1; inc = '0; dec = '0; clr = '0;

    // Expected values for the saturating instance after each cycle.
    add(1, 2'b00, 2'b00, 2'b00, 0, 0, 2'b11);
    add(0, 2'b00, 2'b00, 2'b00, 0, 0, 2'b11);
    for (int p = 1; p <= 3; p++) begin
      add(0, 2'b01, 2'b00, 2'b00, p, 0, 2'b10);
      add(0, 2'b01, 2'b00, 2'b00, p, 0, 2'b10);
      add(0, 2'b00, 2'b00, 2'b00, p, 0, 2'b10);
      add(0, 2'b00, 2'b00, 2'b00, p, 0, 2'b10);
    end
    add(0, 2'b01, 2'b00, 2'b00, 4, 0, 2'b10);
    add(0, 2'b00, 2'b00, 2'b00, 4, 0, 2'b10);
    add(0, 2'b01, 2'b00, 2'b00, 5, 0, 2'b10);
    add(0, 2'b00, 2'b00, 2'b00, 5, 0, 2'b10);
    add(0, 2'b01, 2'b01, 2'b00, 5, 0, 2'b10);
    add(0, 2'b00, 2'b00, 2'b00, 5, 0, 2'b10);
    add(0, 2'b01, 2'b00, 2'b01, 0, 0, 2'b11);
    add(0, 2'b00, 2'b00, 2'b00, 0, 0, 2'b11);

    @(negedge clk);
    foreach (tbl[i]) begin
      rst = tbl[i].rst; inc = tbl[i].inc; dec = tbl[i].dec; clr = tbl[i].clr;
      tick();
      chk($sformatf("tbl[%0d] cnt ch0", i), 32'(ch_of(cnt_s, 0)), 32'(tbl[i].c0));
      chk($sformatf("tbl[%0d] cnt ch1", i), 32'(ch_of(cnt_s, 1)), 32'(tbl[i].c1));
      chk($sformatf("tbl[%0d] at_zero", i), 32'(zero_s), 32'(tbl[i].z));
    end
    rst = 1'b0; inc = '0; dec = '0; clr = '0;

    // 101 presses on ch1: saturate at 99 with sticky clip flag, then clear.
    press(1, 0, 101);
    chk("sat101 cnt ch1", 32'(ch_of(cnt_s, 1)), 32'd99);
    chk("sat101 at_max ch1", 32'(max_s[1]), 32'd1);
    chk("sat101 sat ch1", 32'(sat_s[1]), 32'd1);
    chk("sat101 ch0 untouched", 32'(ch_of(cnt_s, 0)), 32'd0);
    clr[1] = 1'b1; tick(); clr[1] = 1'b0; tick();
    chk("clr cnt ch1", 32'(ch_of(cnt_s, 1)), 32'd0);
    chk("clr sat ch1", 32'(sat_s[1]), 32'd0);

    // Decrement at zero: wrap to MAX on the wrapping instance, clip on the other.
    clr = 2'b11; tick(); clr = 2'b00; tick();
    press(0, 1, 1);
    chk("wrap dec cnt", 32'(ch_of(cnt_w, 0)), 32'd99);
    chk("wrap dec sat", 32'(sat_w[0]), 32'd0);
    chk("satmode dec cnt", 32'(ch_of(cnt_s, 0)), 32'd0);
    chk("satmode dec sat", 32'(sat_s[0]), 32'd1);
    press(0, 0, 1);
    chk("wrap inc cnt", 32'(ch_of(cnt_w, 0)), 32'd0);

    // Button held through reset and through an enable rising edge.
    clr = 2'b11; tick(); clr = 2'b00; tick();
    inc[0] = 1'b1; tick();
    chk("held pre-rst cnt", 32'(ch_of(cnt_s, 0)), 32'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("held rst cnt", 32'(ch_of(cnt_s, 0)), 32'd0);
    tick(); tick();
    chk("held after rst cnt", 32'(ch_of(cnt_s, 0)), 32'd0);
    en = 1'b0; inc[0] = 1'b0; tick();
    inc[0] = 1'b1; tick();
    en = 1'b1; tick(); tick();
    chk("en rise held cnt", 32'(ch_of(cnt_s, 0)), 32'd0);
    inc[0] = 1'b0; tick();
    inc[0] = 1'b1; tick();
    chk("repress cnt", 32'(ch_of(cnt_s, 0)), 32'd1);
    tick(); tick();
    chk("hold one step", 32'(ch_of(cnt_s, 0)), 32'd1);
    inc[0] = 1'b0; tick();

`ifdef SCORE_COUNTER_BCD_EN
    clr = 2'b11; tick(); clr = 2'b00; tick();
    press(0, 0, 47);
    chk("bcd 47", 32'(bcd_s[7:0]), 32'h47);
    clr = 2'b11; tick(); clr = 2'b00; tick();
    press(0, 0, 9);
    chk("bcd 09", 32'(bcd_s[7:0]), 32'h09);
`endif

    // Random traffic: inc-biased first half, dec-biased second half to visit both limits.
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 999) == 0);
      en  = ($urandom_range(0, 7) != 0);
      for (int k = 0; k < NCH; k++) begin
        bit up;
        up = (c < 1500);
        inc[k] = up ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 5) == 0);
        dec[k] = up ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 1) == 1);
        clr[k] = ($urandom_range(0, 511) == 0);
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
